serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 158 +++++++++++++++
 tb/tb_serial_adder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, one full-adder bit per clock, LSB first.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   in_valid   operand set on a, b, cin is valid (sampled only in IDLE)
//   in_ready   high only in IDLE
//   a, b       WIDTH-bit operands
//   cin        carry-in to bit 0
//   out_valid  high only in DONE; sum/cout hold the completed result
//   out_ready  consumer accepts the result
//   sum        a+b+cin modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   busy       high only in RUN
//   ovf        signed overflow, present only when SERIAL_ADDER_OVF_EN is defined
//
// Configuration macro: SERIAL_ADDER_OVF_EN adds the ovf output.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [WIDTH-1:0] a_sh, b_sh, bit_sh;
    logic             ai, bi, s, maj;

    // Select operand bit i by shifting rather than indexing, so the counter
    // width (which must reach WIDTH) never has to match the index width.
    always_comb begin
        a_sh   = a_q >> cnt_q;
        b_sh   = b_q >> cnt_q;
        ai     = a_sh[0];
        bi     = b_sh[0];
        s      = ai ^ bi ^ c_q;
        maj    = (ai & bi) | (ai & c_q) | (bi & c_q);
        bit_sh = {{(WIDTH-1){1'b0}}, s} << cnt_q;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d = sum_q | bit_sh;
                c_d   = maj;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cout_d  = maj;
`ifdef SERIAL_ADDER_OVF_EN
                    // c_q is the carry into the top bit on this last step.
                    ovf_d   = c_q ^ maj;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            c_q         <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            c_q         <= c_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomised checks of serial_adder at WIDTH=8.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait for its result. hold keeps in_valid high
    // with a different operand during RUN; consume releases the result.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input bit hold, input bit consume);
        int edges, busy_cnt, rdy_seen, guard;
        logic [W:0] full;
        logic       exp_ovf;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        chk("idle_wait", 64'(in_ready), 64'd1);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        step();
        if (hold) a = 8'h11;
        else in_valid = 1'b0;
        edges = 0; busy_cnt = 0; rdy_seen = 0;
        while (!out_valid && edges < 100) begin
            if (busy) busy_cnt++;
            if (in_ready) rdy_seen++;
            step();
            edges++;
        end
        in_valid = 1'b0;
        full    = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
        exp_ovf = (ta[W-1] == tb_[W-1]) && (full[W-1] != ta[W-1]);
        chk("latency", 64'(edges), 64'(W));
        chk("busy_cycles", 64'(busy_cnt), 64'(W));
        chk("in_ready_run", 64'(rdy_seen), 64'd0);
        chk("sum", 64'(sum), 64'(full[W-1:0]));
        chk("cout", 64'(cout), 64'(full[W]));
        chk("in_ready_done", 64'(in_ready), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", 64'(ovf), 64'(exp_ovf));
`else
        if (exp_ovf) busy_cnt = 0;
`endif
        if (consume) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk("idle_after", 64'(in_ready), 64'd1);
            chk("ov_after", 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h00, 8'h00, 1'b0, 0, 1);
        chk("zero_sum", 64'(sum), 64'h00);
        run_op(8'hFF, 8'h01, 1'b0, 0, 1);
        run_op(8'h7F, 8'h01, 1'b0, 0, 1);
        run_op(8'hA5, 8'h5A, 1'b1, 1, 1);

        // Back-pressure: result held for 20 cycles, no new accept.
        run_op(8'h1E, 8'h1E, 1'b0, 0, 0);
        a = 8'h44; b = 8'h44; in_valid = 1'b1;
        begin
            int bad = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (!out_valid || sum !== 8'h3C || cout !== 1'b0 || in_ready || busy) bad++;
            end
            chk("hold_stable", 64'(bad), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hold_release_ready", 64'(in_ready), 64'd1);
        chk("hold_release_ov", 64'(out_valid), 64'd0);

        // Reset asserted in the middle of RUN.
        a = 8'h55; b = 8'h66; cin = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sum", 64'(sum), 64'd0);
        chk("mid_rst_cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        run_op(8'h03, 8'h04, 1'b0, 0, 1);
        chk("post_rst_sum", 64'(sum), 64'h07);

        for (int i = 0; i < 200; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
